// File: rtl/ascon_p_ctrl_if.sv
// Request/response handshake bundle between a client and the Ascon permutation controller.
// The client drives the request side and the controller drives the response side.
interface ascon_p_ctrl_if #(
    parameter int BW = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_nr;
    logic [5*BW-1:0]   in_state;
    logic              out_valid;
    logic              out_ready;
    logic [5*BW-1:0]   out_state;

    modport master (
        output in_valid, in_nr, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_nr, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/ascon_p_ctrl.sv
// Ascon permutation controller: issues one core round per cycle and captures the result.
// Also contains the single-round registered core it drives.
module ascon_p_core #(
    parameter int BW = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [3:0]      round,
    input  logic [5*BW-1:0] s_in,
    output logic [5*BW-1:0] s_out
);
    function automatic logic [BW-1:0] ror(input logic [BW-1:0] v, input int n);
        return (v >> n) | (v << (BW - n));
    endfunction

    // Lane x0 sits in the most significant BW bits of the state word.
    function automatic logic [5*BW-1:0] round_fn(input logic [5*BW-1:0] s, input logic [3:0] r);
        logic [BW-1:0] x0, x1, x2, x3, x4;
        logic [BW-1:0] t0, t1, t2, t3, t4;
        logic [7:0]    rc;
        x0 = s[5*BW-1 -: BW];
        x1 = s[4*BW-1 -: BW];
        x2 = s[3*BW-1 -: BW];
        x3 = s[2*BW-1 -: BW];
        x4 = s[BW-1:0];
        rc = {4'hF - r, r};
        x2 = x2 ^ {{(BW-8){1'b0}}, rc};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // One permutation round per clock, result registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_out <= '0;
        end else begin
            s_out <= round_fn(s_in, round);
        end
    end
endmodule

module ascon_p_ctrl #(
    parameter int BW = 64
) (
    input  logic              clk,
    input  logic              rstn,
    ascon_p_ctrl_if.slave     bus,
    output logic [3:0]        core_round,
    output logic [5*BW-1:0]   core_s_in,
    input  logic [5*BW-1:0]   core_s_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      fsm_q, fsm_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5*BW-1:0] state_q, state_d;
    logic [5*BW-1:0] out_state_q, out_state_d;
    logic            out_valid_q, out_valid_d;
    logic            first_q, first_d;
    logic [3:0]      nr_eff_s;

    assign nr_eff_s      = (bus.in_nr > 4'd12) ? 4'd12 : bus.in_nr;
    assign bus.in_ready  = rstn && (fsm_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign core_round    = rnd_q;
    // The core's own output is fed back from the second RUN cycle onward.
    assign core_s_in     = ((fsm_q == RUN) && !first_q) ? core_s_out : state_q;

    // Next-state logic for the request/round/capture sequence.
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        first_d     = first_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    state_d = bus.in_state;
                    if (nr_eff_s == 4'd0) begin
                        out_state_d = bus.in_state;
                        out_valid_d = 1'b1;
                        cnt_d       = 4'd0;
                        fsm_d       = DONE;
                    end else begin
                        rnd_d   = 4'd12 - nr_eff_s;
                        cnt_d   = nr_eff_s;
                        first_d = 1'b1;
                        fsm_d   = RUN;
                    end
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                rnd_d   = rnd_q + 4'd1;
                cnt_d   = cnt_q - 4'd1;
                first_d = 1'b0;
                if (rnd_q == 4'd11) begin
                    fsm_d = CAPT;
                end else begin
                    fsm_d = RUN;
                end
            end
            CAPT: begin
                out_state_d = core_s_out;
                out_valid_d = 1'b1;
                fsm_d       = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                fsm_d       = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            cnt_q       <= 4'd0;
            state_q     <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            first_q     <= first_d;
        end
    end
endmodule

// File: tb/tb_ascon_p_ctrl.sv
// Bench for ascon_p_ctrl driving a real ascon_p_core, checked against a table-lookup
// Ascon permutation model.
module tb_ascon_p_ctrl;
    localparam int BW = 64;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [3:0]      core_round;
    logic [5*BW-1:0] core_s_in;
    logic [5*BW-1:0] core_s_out;

    int total = 0;
    int bad   = 0;

    ascon_p_ctrl_if #(.BW(BW)) bus ();

    ascon_p_ctrl #(.BW(BW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .core_round (core_round),
        .core_s_in  (core_s_in),
        .core_s_out (core_s_out)
    );

    ascon_p_core #(.BW(BW)) core (
        .clk   (clk),
        .rstn  (rstn),
        .round (core_round),
        .s_in  (core_s_in),
        .s_out (core_s_out)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] t;
        t = {v, v} >> n;
        return t[63:0];
    endfunction

    // Reference: last nr rounds of the 12-round schedule, S-box applied column by column.
    function automatic logic [319:0] model_p(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        int          c;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            c = 240 - 15 * r;
            x[2] = x[2] ^ 64'(c);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
            end
            x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
            x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
            x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
            x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
            x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {319'd0, bus.in_ready}, 320'd1);
    endtask

    // One request: checks round sequence, latency, result, DONE hold and return to IDLE.
    task automatic run_req(input logic [3:0] nr, input logic [319:0] st,
                           input int exp_lat, input int exp_first, input int hold);
        int           nre;
        int           lat;
        logic         rounds_ok;
        logic         hold_ok;
        logic [319:0] held;
        nre = (nr > 4'd12) ? 12 : int'(nr);
        wait_idle();
        bus.in_valid  = 1'b1;
        bus.in_nr     = nr;
        bus.in_state  = st;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = (hold > 0);
        bus.in_state = rand_state();
        bus.in_nr    = 4'($urandom_range(0, 15));
        lat = 0;
        rounds_ok = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = j;
                break;
            end
            if (j <= nre && core_round !== 4'(exp_first + j - 1)) rounds_ok = 1'b0;
            if (bus.in_ready) rounds_ok = 1'b0;
        end
        chk("latency", 320'(lat), 320'(exp_lat));
        chk("round_seq", {319'd0, rounds_ok}, 320'd1);
        chk("result", bus.out_state, model_p(st, nre));
        held = bus.out_state;
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_state !== held || bus.in_ready) hold_ok = 1'b0;
        end
        if (hold > 0) chk("done_hold", {319'd0, hold_ok}, 320'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("back_idle", {318'd0, bus.out_valid, bus.in_ready}, 320'd1);
    endtask

    typedef struct {
        logic [3:0] nr;
        logic       fixed_st;
        int         lat;
        int         first;
        int         hold;
    } vec_t;

    vec_t         vecs [7];
    logic [319:0] pat;
    logic         no_valid;

    initial begin
        vecs[0] = '{nr: 4'd12, fixed_st: 1'b0, lat: 14, first: 0,  hold: 0};
        vecs[1] = '{nr: 4'd6,  fixed_st: 1'b0, lat: 8,  first: 6,  hold: 0};
        vecs[2] = '{nr: 4'd0,  fixed_st: 1'b1, lat: 1,  first: 0,  hold: 0};
        vecs[3] = '{nr: 4'd15, fixed_st: 1'b0, lat: 14, first: 0,  hold: 0};
        vecs[4] = '{nr: 4'd1,  fixed_st: 1'b0, lat: 3,  first: 11, hold: 0};
        vecs[5] = '{nr: 4'd13, fixed_st: 1'b1, lat: 14, first: 0,  hold: 0};
        vecs[6] = '{nr: 4'd12, fixed_st: 1'b0, lat: 14, first: 0,  hold: 5};
        pat = {5{64'h0123456789abcdef}};

        bus.in_valid  = 1'b0;
        bus.in_nr     = 4'd0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
        rstn          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", {319'd0, bus.in_ready}, 320'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {319'd0, bus.in_ready}, 320'd1);
        chk("rst_out_valid", {319'd0, bus.out_valid}, 320'd0);
        chk("rst_out_state", bus.out_state, 320'd0);
        chk("rst_core_round", {316'd0, core_round}, 320'd0);
        chk("rst_core_s_in", core_s_in, 320'd0);

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].nr, vecs[i].fixed_st ? pat : rand_state(),
                    vecs[i].lat, vecs[i].first, vecs[i].hold);
        end

        // Abort at the third RUN cycle with a one-edge reset pulse.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_nr    = 4'd12;
        bus.in_state = rand_state();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {319'd0, bus.in_ready}, 320'd1);
        chk("abort_out_state", bus.out_state, 320'd0);
        chk("abort_core_round", {316'd0, core_round}, 320'd0);
        no_valid = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (bus.out_valid) no_valid = 1'b0;
        end
        chk("abort_no_valid", {319'd0, no_valid}, 320'd1);
        run_req(4'd12, rand_state(), 14, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [3:0] nr;
            int         nre;
            nr  = 4'($urandom_range(0, 15));
            nre = (nr > 4'd12) ? 12 : int'(nr);
            run_req(nr, rand_state(), (nre == 0) ? 1 : nre + 2, 12 - nre,
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ascon_p_ctrl.md
ASCON_P_CTRL -- requirements
Module: ascon_p_ctrl

Interface
REQ-001 Parameter: BW, default 64, lane width in bits; state width is 5*BW.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rstn  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  request carries a valid state and round count.
REQ-005 Port: in_ready  output  1  controller can accept a request.
REQ-006 Port: in_nr  input  4  number of rounds requested.
REQ-007 Port: in_state  input  5*BW  permutation input state.
REQ-008 Port: out_valid  output  1  out_state holds a finished result.
REQ-009 Port: out_ready  input  1  downstream consumes the result.
REQ-010 Port: out_state  output  5*BW  permuted state.
REQ-011 Port: core_round  output  4  round index driven to the ascon_p_core round input.
REQ-012 Port: core_s_in  output  5*BW  state driven to the ascon_p_core s_in input.
REQ-013 Port: core_s_out  input  5*BW  ascon_p_core s_out, registered in the core, valid one edge after core_round/core_s_in are sampled.

Function
REQ-014 FSM states SHALL be IDLE, RUN, CAPT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE with rstn high; a transfer occurs on an edge with in_valid and in_ready both 1.
REQ-016 On transfer, the block SHALL latch in_state into the state register and compute nr_eff = 12 when in_nr > 12, else in_nr.
REQ-017 With nr_eff = 0, the block SHALL copy in_state to out_state and enter DONE; out_valid is 1 after the transfer edge.
REQ-018 With nr_eff in 1..12, the block SHALL enter RUN with round register = 12 - nr_eff and round counter = nr_eff.
REQ-019 In RUN, core_round SHALL equal the round register.
REQ-020 In RUN, core_s_in SHALL equal the latched state register on the first RUN cycle and core_s_out on every later RUN cycle.
REQ-021 Each RUN edge SHALL increment the round register and decrement the counter, so one round is issued per cycle.
REQ-022 The RUN edge that issues round index 11 SHALL move the FSM to CAPT.
REQ-023 The CAPT edge SHALL load out_state from core_s_out and move the FSM to DONE.
REQ-024 Latency SHALL be exactly nr_eff+2 edges from the transfer edge to the first edge at which out_valid is sampled high, for nr_eff >= 1.
REQ-025 In DONE, out_valid SHALL be 1 and out_state SHALL be stable until an edge with out_ready high, which returns the FSM to IDLE.
REQ-026 A new request SHALL be accepted no earlier than the cycle after the DONE to IDLE edge; there is no input/output overlap.
REQ-027 In IDLE, CAPT and DONE, core_round SHALL hold the round register value and core_s_in SHALL equal the state register.
REQ-028 in_valid and in_state SHALL be ignored outside IDLE.
REQ-029 out_ready SHALL be ignored outside DONE.

Reset
REQ-030 On an edge with rstn low, the FSM SHALL go to IDLE, and out_valid, the round register, the counter, the state register and out_state SHALL all be 0.
REQ-031 Reset mid-operation (RUN, CAPT or DONE) SHALL abort the request with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rstn returns high.

Verification
REQ-032 The bench SHALL use a real ascon_p_core and a software Ascon permutation model as the reference; it SHALL cover:
- in_nr=12, random state, out_ready=1 -> core_round sequence 0..11; out_valid high 14 edges after transfer; out_state equals model p12(state).
- in_nr=6 -> core_round sequence 6..11; out_valid high 8 edges after transfer; out_state equals model p6(state).
- in_nr=0, state=0x0123...(320b) -> out_valid 1 edge after transfer; out_state equals in_state bit-exact.
- in_nr=15 -> same round sequence, latency and result as in_nr=12.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, out_state unchanged, in_ready stays 0; release -> IDLE next cycle.
- rstn low for 1 edge at the third RUN cycle -> no out_valid; in_ready=1 in the first cycle after rstn returns high; next request with in_nr=12 gives the correct p12 result.
